// File: rtl/temp_avg_ctrl_if.sv
// Bundles the FIFO read port and RAM write port seen by temp_avg_ctrl.
// master = the averaging controller, slave = the FIFO/RAM side.
interface temp_avg_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              halt;
    logic              fifo_rd;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              busy;
    logic              wrap;

    modport master (
        input  fifo_empty, fifo_data, halt,
        output fifo_rd, ram_wr, ram_addr, ram_data, busy, wrap
    );

    modport slave (
        output fifo_empty, fifo_data, halt,
        input  fifo_rd, ram_wr, ram_addr, ram_data, busy, wrap
    );
endinterface

// File: rtl/temp_avg_ctrl.sv
// Averages each 4-byte temperature packet from the FIFO into a wrapping RAM address.
// Latency: ram_wr 9 cycles after the IDLE cycle that first sees data; 2 cycles per byte.
// Backpressure: no read is started while fifo_empty or halt; partial packets park in IDLE.
module temp_avg_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    temp_avg_ctrl_if.master   bus
);
    localparam int                ACC_W     = DATA_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              can_read;
    logic              fifo_rd_c;
    logic              ram_wr_c;
    logic              busy_c;
    logic              wrap_c;

    assign can_read = !bus.fifo_empty && !bus.halt;
    assign sum      = acc + ACC_W'(bus.fifo_data);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = can_read ? READ : IDLE;
            READ:    state_nxt = CAPTURE;
            CAPTURE: begin
                if (cnt == 2'd3) begin
                    state_nxt = WRITE;
                end else if (can_read) begin
                    state_nxt = READ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are pure state decodes so they last exactly one cycle.
    always_comb begin
        fifo_rd_c = (state == READ);
        ram_wr_c  = (state == WRITE);
        wrap_c    = (state == WRITE) && (ram_addr_q == LAST_ADDR);
        busy_c    = (state != IDLE) || (cnt != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= 2'd0;
            acc        <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    acc <= sum;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        ram_data_q <= sum[ACC_W-1:2];
                    end
                end
                WRITE: begin
                    acc        <= '0;
                    cnt        <= 2'd0;
                    ram_addr_q <= (ram_addr_q == LAST_ADDR) ? '0 : ram_addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rd  = fifo_rd_c;
    assign bus.ram_wr   = ram_wr_c;
    assign bus.wrap     = wrap_c;
    assign bus.busy     = busy_c;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
endmodule

// File: tb/tb_temp_avg_ctrl.sv
// Directed bench: dut_a uses RAM_DEPTH=256, dut_b RAM_DEPTH=4; both share one FIFO model.
module tb_temp_avg_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       halt;

    temp_avg_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
    temp_avg_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

    assign ifa.fifo_empty = fifo_empty;
    assign ifa.fifo_data  = fifo_data;
    assign ifa.halt       = halt;
    assign ifb.fifo_empty = fifo_empty;
    assign ifb.fifo_data  = fifo_data;
    assign ifb.halt       = halt;

    temp_avg_ctrl #(.DATA_W(8), .ADDR_W(8), .RAM_DEPTH(256)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.master)
    );
    temp_avg_ctrl #(.DATA_W(8), .ADDR_W(8), .RAM_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] avg;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] q [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         rd_viol = 0;
    logic       prev_empty = 1'b1;
    logic       prev_halt = 1'b0;
    int         rd_log [$];
    int         wr_cyc [$];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    logic       wr_wrap [$];
    logic [7:0] b_addr [$];
    logic       b_wrap [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the FIFO model.
    task automatic clk_cycle();
        prev_empty = fifo_empty;
        prev_halt  = halt;
        @(negedge clk);
        cyc++;
        if (ifa.fifo_rd && (prev_empty || prev_halt)) rd_viol++;
        if (ifa.fifo_rd) rd_log.push_back(cyc);
        if (ifa.ram_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(ifa.ram_addr);
            wr_data.push_back(ifa.ram_data);
            wr_wrap.push_back(ifa.wrap);
        end
        if (ifb.ram_wr) begin
            b_addr.push_back(ifb.ram_addr);
            b_wrap.push_back(ifb.wrap);
        end
        if (ifa.fifo_rd && q.size() > 0) fifo_data = q.pop_front();
        fifo_empty = (q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        wr_wrap.delete(); b_addr.delete(); b_wrap.delete();
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input int n);
        q.push_back(a);
        if (n > 1) q.push_back(b);
        fifo_empty = (q.size() == 0);
        t0 = cyc;
    endtask

    task automatic load4(input vec_t v);
        q.push_back(v.b0); q.push_back(v.b1); q.push_back(v.b2); q.push_back(v.b3);
        fifo_empty = 1'b0;
        t0 = cyc;
    endtask

    task automatic do_reset(input int n);
        q.delete();
        fifo_empty = 1'b1;
        reset_n = 1'b0;
        run(n);
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " fifo_rd"},  32'(ifa.fifo_rd),  0);
        chk({tag, " ram_wr"},   32'(ifa.ram_wr),   0);
        chk({tag, " ram_addr"}, 32'(ifa.ram_addr), 0);
        chk({tag, " ram_data"}, 32'(ifa.ram_data), 0);
        chk({tag, " busy"},     32'(ifa.busy),     0);
        chk({tag, " wrap"},     32'(ifa.wrap),     0);
    endtask

    task automatic check_one_write(input string tag, input logic [7:0] addr, input logic [7:0] data);
        chk({tag, " write count"}, 32'(wr_data.size()), 1);
        chk({tag, " ram_addr"}, 32'((wr_addr.size() > 0) ? wr_addr[0] : 8'hxx), 32'(addr));
        chk({tag, " ram_data"}, 32'((wr_data.size() > 0) ? wr_data[0] : 8'hxx), 32'(data));
    endtask

    initial begin
        vecs[0] = '{b0: 8'd10,  b1: 8'd20,  b2: 8'd30,  b3: 8'd40,  avg: 8'd25};
        vecs[1] = '{b0: 8'hFF,  b1: 8'hFF,  b2: 8'hFF,  b3: 8'hFF,  avg: 8'hFF};
        vecs[2] = '{b0: 8'd1,   b1: 8'd1,   b2: 8'd1,   b3: 8'd0,   avg: 8'd0};
        vecs[3] = '{b0: 8'd3,   b1: 8'd4,   b2: 8'd5,   b3: 8'd6,   avg: 8'd4};
        vecs[4] = '{b0: 8'd0,   b1: 8'd0,   b2: 8'd0,   b3: 8'd0,   avg: 8'd0};
        vecs[5] = '{b0: 8'd255, b1: 8'd255, b2: 8'd255, b3: 8'd0,   avg: 8'd191};
        vecs[6] = '{b0: 8'd100, b1: 8'd101, b2: 8'd102, b3: 8'd103, avg: 8'd101};

        fifo_data  = 8'd0;
        fifo_empty = 1'b1;
        halt       = 1'b0;
        reset_n    = 1'b0;
        do_reset(3);
        check_idle("reset");

        // Table: one packet per vector, addresses incrementing from 0.
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            load4(vecs[i]);
            run(12);
            check_one_write($sformatf("vec%0d", i), 8'(i), vecs[i].avg);
            chk($sformatf("vec%0d wrap", i), 32'((wr_wrap.size() > 0) ? wr_wrap[0] : 1'bx), 0);
            chk($sformatf("vec%0d ram_wr cycle", i),
                (wr_cyc.size() > 0) ? 32'(wr_cyc[0] - t0) : 32'hFFFF_FFFF, 9);
            if (i == 0) begin
                chk("vec0 rd count", 32'(rd_log.size()), 4);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("vec0 rd%0d cycle", k),
                        (rd_log.size() > k) ? 32'(rd_log[k] - t0) : 32'hFFFF_FFFF, 32'(2 * k + 1));
            end
        end

        // Empty gap mid-packet: partial sum retained, busy held.
        do_reset(1);
        load(8'd8, 8'd8, 2);
        run(6);
        begin
            int busy_low = 0;
            for (int i = 0; i < 20; i++) begin
                clk_cycle();
                if (!ifa.busy) busy_low++;
            end
            chk("gap busy low cycles", 32'(busy_low), 0);
            chk("gap writes", 32'(wr_data.size()), 0);
        end
        load(8'd8, 8'd8, 2);
        run(12);
        check_one_write("gap", 8'd0, 8'd8);

        // Reset mid-packet discards the two collected bytes.
        do_reset(1);
        load(8'd50, 8'd60, 2);
        run(4);
        do_reset(1);
        check_idle("midreset");
        load4('{b0: 8'd4, b1: 8'd4, b2: 8'd4, b3: 8'd4, avg: 8'd4});
        run(12);
        check_one_write("midreset", 8'd0, 8'd4);

        // Halt blocks reads while data is waiting.
        do_reset(1);
        halt = 1'b1;
        load4('{b0: 8'd20, b1: 8'd20, b2: 8'd20, b3: 8'd24, avg: 8'd21});
        run(5);
        chk("halt rd count", 32'(rd_log.size()), 0);
        halt = 1'b0;
        t0 = cyc;
        run(12);
        chk("halt release rd cycle",
            (rd_log.size() > 0) ? 32'(rd_log[0] - t0) : 32'hFFFF_FFFF, 1);
        check_one_write("halt", 8'd0, 8'd21);

        // Address wrap on the RAM_DEPTH=4 instance.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            load4(vecs[i]);
            run(12);
        end
        chk("wrap b write count", 32'(b_addr.size()), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrap b addr%0d", k),
                32'((b_addr.size() > k) ? b_addr[k] : 8'hxx), 32'(k % 4));
            chk($sformatf("wrap b pulse%0d", k),
                32'((b_wrap.size() > k) ? b_wrap[k] : 1'bx), (k == 3) ? 1 : 0);
        end
        chk("wrap a addr4", 32'((wr_addr.size() > 4) ? wr_addr[4] : 8'hxx), 4);
        begin
            int a_wraps = 0;
            foreach (wr_wrap[k]) if (wr_wrap[k] !== 1'b0) a_wraps++;
            chk("wrap a pulses", 32'(a_wraps), 0);
        end

        chk("fifo_rd while empty/halt", 32'(rd_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
